// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Default geometry, read-mode encodings and the depth helper live here.
package fifo_pkg;

    localparam int unsigned DEF_DATA_SIZE = 8;
    localparam int unsigned DEF_ADDR_SIZE = 4;

    localparam int unsigned MODE_STD  = 0;
    localparam int unsigned MODE_FWFT = 1;

    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage array for sync_fifo: synchronous write, combinational read.
// Contents are deliberately not reset.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 wclk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge wclk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, almost-full/almost-empty thresholds, sticky error flags and flush.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned FWFT      = MODE_STD,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned AE_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);
    localparam logic [ADDR_SIZE:0] AF_LEVEL = (ADDR_SIZE+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_SIZE:0] AE_LEVEL = (ADDR_SIZE+1)'(AE_MARGIN);
    localparam logic [ADDR_SIZE:0] PTR_ONE  = (ADDR_SIZE+1)'(1);

    logic [ADDR_SIZE:0]   wptr;
    logic [ADDR_SIZE:0]   rptr;
    logic [ADDR_SIZE:0]   cnt;
    logic                 ovf_q;
    logic                 udf_q;
    logic                 full_w;
    logic                 empty_w;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [DATA_SIZE-1:0] mem_rdata;

    // Extra pointer MSB separates the full and empty cases when low bits match.
    assign full_w  = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                     (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
    assign empty_w = (wptr == rptr);

    assign wr_accept = wr_en & ~full_w & ~flush;
    assign rd_accept = rd_en & ~empty_w & ~flush;

    sync_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .wclk  (clk),
        .wr_en (wr_accept),
        .waddr (wptr[ADDR_SIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ADDR_SIZE-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_accept) wptr <= wptr + PTR_ONE;
            if (rd_accept) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            unique case ({wr_accept, rd_accept})
                2'b10:   cnt <= cnt + PTR_ONE;
                2'b01:   cnt <= cnt - PTR_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && full_w)  ovf_q <= 1'b1;
            if (rd_en && empty_w) udf_q <= 1'b1;
        end
    end

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word straight from the array; forced to zero while empty so
            // uninitialised storage never reaches the port.
            assign rdata = empty_w ? '0 : mem_rdata;
        end else begin : g_std
            logic [DATA_SIZE-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_accept) begin
                    rdata_q <= mem_rdata;
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = cnt;
    assign almost_full  = (cnt >= AF_LEVEL);
    assign almost_empty = (cnt <= AE_LEVEL);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO for same-domain buffering. It pairs with the async FIFO path and adds the following:
- selectable standard or first-word-fall-through (FWFT) read mode
- occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- synchronous flush

Used between producer/consumer stages that share clk.

Parameters:
DATA_SIZE, 8, data word width in bits
ADDR_SIZE, 4, address width; DEPTH = 1<<ADDR_SIZE (default 16)
FWFT, 0, 0 = standard read (registered rdata, 1-cycle latency); 1 = first-word-fall-through
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1
AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers, count and error flags
wr_en  input  1  write request
wdata  input  DATA_SIZE  write data
rd_en  input  1  read/pop request
rdata  output  DATA_SIZE  read data
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
almost_full  output  1  count >= DEPTH-AF_MARGIN
almost_empty  output  1  count <= AE_MARGIN
count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata=0. Memory contents are not reset.
- Pointers are ADDR_SIZE+1 bits and wrap modulo 2*DEPTH. The low ADDR_SIZE bits address memory.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
- All flags and count derive from registered state. They reflect an access on the cycle after the capturing edge.
- Accept conditions:
  - wr_accept = wr_en & ~full
  - rd_accept = rd_en & ~empty
  - Both are evaluated on pre-edge state.
- Write: on wr_accept, mem[wptr] <= wdata and wptr increments.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- When full with wr_en and rd_en both high: the read is accepted, the write is dropped, and overflow is set.
- When empty with wr_en and rd_en both high: the write is accepted, the read is dropped, and underflow is set.
- Standard mode (FWFT=0): on rd_accept, rdata <= mem[rptr] at the same edge and rptr increments. Data is valid the cycle after rd_en. Otherwise rdata holds its last value.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr], combinational from registered rptr, whenever empty=0. Don't-care while empty.
  - rd_en acknowledges/pops the head.
  - A word written into an empty FIFO is visible on rdata one cycle after the write edge, when empty falls.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. It never exceeds DEPTH or goes below 0.
- overflow and underflow: set on wr_en&full and rd_en&empty respectively. Cleared only by flush or reset.
- flush: synchronous and highest priority. It sets pointers/count to 0, empty=1, full=0, and clears overflow/underflow. wr_en/rd_en in the flush cycle are ignored. rdata holds its value in standard mode.
- Wrap-around: writing DEPTH+k words with interleaved reads must preserve order across pointer wrap.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_SIZE/ADDR_SIZE constants
  - localparam function for DEPTH
  - FWFT mode constants (MODE_STD=0, MODE_FWFT=1)
- Sub-module sync_fifo_mem holds the dual-port array:
  - synchronous write
  - combinational read port
- sync_fifo holds pointers, count, flags and the read-mode register/bypass.

Test Plan:
1. Reset then idle (defaults) -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, rdata=0.
2. Write 0x01..0x10 (16 words) -> full=1, count=16; almost_full rises when count=14. A 17th write sets overflow=1 with count still 16. Read 16 (FWFT=0) -> rdata 0x01..0x10 in order, each one cycle after rd_en; then empty=1.
3. FWFT=1: write 0xA5 into empty FIFO -> empty=0 and rdata=0xA5 the next cycle without rd_en. Pulse rd_en -> empty=1 the next cycle.
4. Fill to 16, then wr_en=rd_en=1 for one cycle with wdata=0xFF -> head popped, count=15, overflow=1, 0xFF not stored. At empty, wr_en=rd_en=1 with 0x3C -> count=1, underflow=1, next read returns 0x3C.
5. Wrap: continuous simultaneous rd/wr for 40 cycles at count=5 with incrementing data -> count stays 5 and output sequence matches input delayed by 5 words.
6. Flush at count=9 with overflow=1, wr_en=1 same cycle -> next cycle count=0, empty=1, overflow=0, and the write was dropped. Assert rst_n low mid-burst -> all outputs return to reset values immediately.
